// File: rtl/ifetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: sizing, reset PC and
// the fetch-response record stored per queued instruction.
package ifetch_buffer_pkg;

  localparam int          IFB_DEPTH  = 4;
  localparam logic [31:0] INITIAL_PC = 32'h0000_0200;

  // Kept as a struct so per-fetch status (e.g. a bus fault flag) can be added.
  typedef struct packed {
    logic [31:0] instr;
  } fetch_rsp_t;

  function automatic logic [31:0] align_word(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Generic synchronous FIFO with a synchronous clear; full/empty come from an
// extra wrap bit on each pointer.
module ifb_fifo
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  fetch_rsp_t push_data,
  input  logic       pop,
  output fetch_rsp_t head,
  output logic       full,
  output logic       empty
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  fetch_rsp_t  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full && !clear;
  assign do_pop_s  = pop && !empty && !clear;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Pointer update with clear taking priority over push and pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch buffer: credit-limited request issue to IROM, in-order
// response queueing, redirect flush with stale-response dropping.
module ifetch_buffer
  import ifetch_buffer_pkg::*;
#(
  parameter int DEPTH  = IFB_DEPTH,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       pc4_o,
  input  logic              instr_ready_i
);

  localparam int          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(DEPTH);

  logic [31:0]   fpc_r;
  logic [31:0]   hpc_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;

  logic [CW:0]   credit_used_s;
  logic          req_s;
  logic          fire_s;
  logic          discard_s;
  logic          push_s;
  logic          pop_s;
  logic          valid_s;
  logic [CW-1:0] inflight_after_rsp_s;
  logic [CW-1:0] inflight_nxt_s;
  logic [CW-1:0] count_nxt_s;
  fetch_rsp_t    rsp_s;
  fetch_rsp_t    head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  // Credits cover queued entries plus live (not-to-be-dropped) fetches.
  assign credit_used_s = {1'b0, count_r} + {1'b0, inflight_r} - {1'b0, drop_r};
  assign req_s         = rst_n && !redirect_i && (credit_used_s < DEPTH_C);
  assign fire_s        = req_s && imem_gnt_i;
  assign discard_s     = (drop_r != CNT_ZERO);
  assign push_s        = imem_rvalid_i && !discard_s && !redirect_i && !fifo_full_s;
  assign valid_s       = rst_n && (count_r != CNT_ZERO);
  assign pop_s         = valid_s && instr_ready_i && !redirect_i && !fifo_empty_s;

  assign inflight_after_rsp_s = imem_rvalid_i ? (inflight_r - CNT_ONE) : inflight_r;
  assign inflight_nxt_s       = fire_s ? (inflight_after_rsp_s + CNT_ONE) : inflight_after_rsp_s;

  // Next queue occupancy for the non-redirect case.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Fetch/head PCs and counters; redirect overrides push, pop and responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_r      <= INITIAL_PC;
      hpc_r      <= INITIAL_PC;
      count_r    <= CNT_ZERO;
      inflight_r <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
    end else if (redirect_i) begin
      fpc_r      <= align_word(redirect_pc_i);
      hpc_r      <= align_word(redirect_pc_i);
      count_r    <= CNT_ZERO;
      inflight_r <= inflight_after_rsp_s;
      drop_r     <= inflight_after_rsp_s;
    end else begin
      if (fire_s) begin
        fpc_r <= fpc_r + 32'd4;
      end
      if (pop_s) begin
        hpc_r <= hpc_r + 32'd4;
      end
      if (imem_rvalid_i && discard_s) begin
        drop_r <= drop_r - CNT_ONE;
      end
      count_r    <= count_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  assign rsp_s.instr = imem_rdata_i;

  ifb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_i),
    .push      (push_s),
    .push_data (rsp_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign imem_req_o    = req_s;
  assign imem_addr_o   = fpc_r[ADDR_W+1:2];
  assign instr_valid_o = valid_s;
  assign instr_o       = head_s.instr;
  assign pc_o          = hpc_r;
  assign pc4_o         = hpc_r + 32'd4;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomized bench for ifetch_buffer against a queue-based fetch-stream model
// with a variable-latency, in-order instruction memory.
module tb_ifetch_buffer;
  import ifetch_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              redirect_i;
  logic [31:0]       redirect_pc_i;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [31:0]       imem_rdata_i;
  logic              instr_valid_o;
  logic [31:0]       instr_o;
  logic [31:0]       pc_o;
  logic [31:0]       pc4_o;
  logic              instr_ready_i;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc4_o         (pc4_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          stale;
    int          due;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  flight_t     fl_q[$];
  entry_t      q[$];
  logic [31:0] m_fpc;
  int          cyc;
  int          n_tests;
  int          n_fail;
  int          lat_min;
  int          lat_max;

  logic              snap_req;
  logic              snap_valid;
  logic [ADDR_W-1:0] snap_addr;
  logic [31:0]       snap_pc;
  logic [31:0]       snap_pc4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit gnt);
    bit      exp_req;
    bit      rv;
    bit      do_pop;
    int      live;
    flight_t f;
    entry_t  e;
    @(negedge clk);
    rst_n         = !rst;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    imem_gnt_i    = gnt;
    rv            = !rst && (fl_q.size() > 0) && (fl_q[0].due <= cyc);
    imem_rvalid_i = rv;
    imem_rdata_i  = rv ? fl_q[0].data : $urandom;
    #1;
    live = q.size();
    foreach (fl_q[i]) if (!fl_q[i].stale) live++;
    exp_req = !rst && !redir && (live < DEPTH);
    check_eq("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    if (exp_req) check_eq("addr", {18'd0, imem_addr_o}, {18'd0, m_fpc[ADDR_W+1:2]});
    check_eq("valid", {31'd0, instr_valid_o}, {31'd0, (!rst && q.size() != 0)});
    if (!rst && q.size() != 0) begin
      check_eq("instr", instr_o, q[0].instr);
      check_eq("pc", pc_o, q[0].pc);
      check_eq("pc4", pc4_o, q[0].pc + 32'd4);
    end
    snap_req   = imem_req_o;
    snap_valid = instr_valid_o;
    snap_addr  = imem_addr_o;
    snap_pc    = pc_o;
    snap_pc4   = pc4_o;
    do_pop     = !rst && !redir && rdy && (q.size() != 0);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      fl_q.delete();
      m_fpc = INITIAL_PC;
    end else if (redir) begin
      if (rv) void'(fl_q.pop_front());
      foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      q.delete();
      m_fpc = {rpc[31:2], 2'b00};
    end else begin
      if (do_pop) void'(q.pop_front());
      if (rv) begin
        f = fl_q.pop_front();
        if (!f.stale) begin
          e.pc    = f.pc;
          e.instr = f.data;
          q.push_back(e);
        end
      end
      if (exp_req && gnt) begin
        f.pc    = m_fpc;
        f.data  = $urandom;
        f.stale = 1'b0;
        f.due   = cyc - 1 + $urandom_range(lat_max, lat_min);
        fl_q.push_back(f);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_req", {31'd0, snap_req}, 32'd0);
    check_eq("rst_valid", {31'd0, snap_valid}, 32'd0);
  endtask

  initial begin
    int          grants;
    bit          seen;
    logic [31:0] first_pc;
    logic [31:0] exp_addr;
    n_tests = 0; n_fail = 0; cyc = 0;
    lat_min = 1; lat_max = 1;
    m_fpc = INITIAL_PC;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0; instr_ready_i = 1'b0;

    // Streaming after reset, latency 1, always ready.
    do_reset();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (i == 0) check_eq("reset_pc", snap_pc, INITIAL_PC);
      exp_addr = (INITIAL_PC >> 2) + i;
      if (i < 3) check_eq("stream_addr", {18'd0, snap_addr}, exp_addr & 32'h3FFF);
      if (i == 2) check_eq("first_valid", {31'd0, snap_valid}, 32'd1);
    end

    // Stall: exactly DEPTH grants, head held, then drain without gaps.
    do_reset();
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
      if (snap_req) grants++;
    end
    check_eq("stall_grants", grants, DEPTH);
    check_eq("stall_pc", snap_pc, INITIAL_PC);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      check_eq("drain_valid", {31'd0, snap_valid}, 32'd1);
    end

    // Redirect with three fetches in flight at latency 5.
    lat_min = 5; lat_max = 5;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
    check_eq("redir_req_masked", {31'd0, snap_req}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_eq("redir_addr", {18'd0, snap_addr}, 32'h0000_0040);
    seen = 1'b0; first_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
      if (snap_valid && !seen) begin seen = 1'b1; first_pc = snap_pc; end
    end
    check_eq("redir_first_pc", first_pc, 32'h0000_0100);

    // Fetch PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    do_reset();
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_eq("wrap_addr_hi", {18'd0, snap_addr}, 32'h0000_3FFF);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("wrap_addr_lo", {18'd0, snap_addr}, 32'h0000_0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (snap_valid && !seen) begin
        seen = 1'b1;
        check_eq("wrap_pc", snap_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc4", snap_pc4, 32'h0000_0000);
      end
    end
    check_eq("wrap_seen", {31'd0, seen}, 32'd1);

    // Randomized traffic: grants, latency, stalls, redirects and resets.
    for (int ph = 0; ph < 4; ph++) begin
      lat_min = 1;
      lat_max = (ph == 0) ? 1 : 2 + 2 * ph;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        step(($urandom_range(999, 0) < 4),
             ($urandom_range(99, 0) < 3 + 2 * ph),
             $urandom,
             ($urandom_range(99, 0) < 90 - 15 * ph),
             ($urandom_range(99, 0) < 95 - 15 * ph));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
